// File: rtl/seg_pkg.sv
// Shared definitions for the multiplexed 7-segment display arbiter.
// Contents:
//   SEG_BLANK   - digit code that drives no segments
//   SEL_OFF     - active-low digit select with every digit disabled
//   NUM_DIGITS  - number of multiplexed digits
//   seg_state_e - arbiter state (IDLE: nothing granted, SHOW: one grantee)
//   rr_pick     - round-robin search helper
package seg_pkg;

  localparam logic [4:0]  SEG_BLANK  = 5'h10;
  localparam logic [3:0]  SEL_OFF    = 4'b1111;
  localparam int unsigned NUM_DIGITS = 4;

  typedef enum logic {
    IDLE = 1'b0,
    SHOW = 1'b1
  } seg_state_e;

  // Round-robin search over the four requesters, starting at start_after+1
  // and wrapping, so start_after itself is the last candidate.
  // Returns {found, index}.
  function automatic logic [2:0] rr_pick(input logic [3:0] req_v,
                                         input logic [1:0] start_after);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    // Walk from the farthest candidate back to the nearest so the nearest
    // requester is the one left in res.
    for (int k = 4; k >= 1; k--) begin
      idx = start_after + 2'(k);
      if (req_v[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

endpackage

// File: rtl/seg_scan_timer.sv
// Scan timing for the multiplexed display.
// A slot counter runs 0..SCAN_DIV-1; every wrap advances the digit index
// 0,1,2,3,0. The first BLANK_CYC cycles of each slot are the anti-ghost
// blank window. The frame boundary is the last cycle of digit 3.
// Ports:
//   clk_i       clock
//   rst_ni      asynchronous active-low reset (restarts at digit 0, slot 0)
//   digit_o     current digit index
//   blank_o     high while the slot counter is inside the blank window
//   boundary_o  high on the frame-boundary cycle
module seg_scan_timer
  import seg_pkg::*;
#(
  parameter int unsigned SCAN_DIV  = 166667,
  parameter int unsigned BLANK_CYC = 1000
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  output logic [1:0] digit_o,
  output logic       blank_o,
  output logic       boundary_o
);

  localparam int unsigned   CW        = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] SLOT_LAST = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYC);
  localparam logic [1:0]    DIG_LAST  = 2'(NUM_DIGITS - 1);

  logic [CW-1:0] slot_q, slot_d;
  logic [1:0]    digit_q, digit_d;
  logic          slot_wrap;

  assign slot_wrap = (slot_q == SLOT_LAST);

  always_comb begin
    slot_d  = slot_q + 1'b1;
    digit_d = digit_q;
    if (slot_wrap) begin
      slot_d  = '0;
      digit_d = digit_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      slot_q  <= '0;
      digit_q <= 2'd0;
    end else begin
      slot_q  <= slot_d;
      digit_q <= digit_d;
    end
  end

  assign digit_o    = digit_q;
  assign blank_o    = (slot_q < BLANK_END);
  assign boundary_o = slot_wrap && (digit_q == DIG_LAST);

endmodule

// File: rtl/seg_display_arbiter.sv
// Four requesters share one 4-digit multiplexed hex display. A round-robin
// arbiter hands the display to one requester per frame boundary; a grantee
// keeps it for DWELL_FRAMES frames (or indefinitely while hold is high and
// it keeps requesting). The grantee's 16-bit value is latched at every frame
// boundary, so data changes mid-frame never reach the digits.
// Optional feature: define SEG_LZ_BLANK_EN to blank leading-zero digits
// (digit 0 is always shown). Without it all four nibbles are shown.
// Parameter constraints: SCAN_DIV > BLANK_CYC, DWELL_FRAMES >= 1.
// Ports:
//   clk         clock
//   rst_n       asynchronous active-low reset
//   req[3:0]    display request per requester
//   data[63:0]  requester i value in data[16i+15:16i]
//   hold        freeze rotation on the current grantee
//   grant[3:0]  one-hot current grantee (0 = none)
//   seg_code    registered digit code (0..15 hex nibble, 5'h10 blank)
//   sel[3:0]    registered active-low digit select (4'b1111 all off)
//   frame_tick  one-cycle pulse on the first cycle of each frame
// Outputs sel/seg_code lag the scan counter state by one cycle.
module seg_display_arbiter
  import seg_pkg::*;
#(
  parameter int unsigned SCAN_DIV     = 166667,
  parameter int unsigned BLANK_CYC    = 1000,
  parameter int unsigned DWELL_FRAMES = 75
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  req,
  input  logic [63:0] data,
  input  logic        hold,
  output logic [3:0]  grant,
  output logic [4:0]  seg_code,
  output logic [3:0]  sel,
  output logic        frame_tick
);

  localparam int unsigned   DW         = (DWELL_FRAMES > 1) ? $clog2(DWELL_FRAMES) : 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_FRAMES - 1);

  logic [1:0] digit;
  logic       blank;
  logic       boundary;

  seg_scan_timer #(
    .SCAN_DIV (SCAN_DIV),
    .BLANK_CYC(BLANK_CYC)
  ) u_timer (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .digit_o   (digit),
    .blank_o   (blank),
    .boundary_o(boundary)
  );

  seg_state_e    state_q, state_d;
  logic [3:0]    grant_q, grant_d;
  logic [1:0]    last_q, last_d;     // most recent grantee, RR search origin
  logic [DW-1:0] dwell_q, dwell_d;
  logic [15:0]   value_q, value_d;
  logic [3:0]    sel_q, sel_d;
  logic [4:0]    seg_q, seg_d;
  logic          tick_q;
  logic [2:0]    pick;
  logic          rearb;
  logic [3:0]    nibble;

  // Arbiter: all decisions happen on the frame-boundary cycle only.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    dwell_d = dwell_q;
    value_d = value_q;
    rearb   = 1'b0;
    // In SHOW last_q is the current grantee, so one search serves both states.
    pick    = rr_pick(req, last_q);
    if (boundary) begin
      if (state_q == IDLE) begin
        rearb = 1'b1;
      end else begin
        // Req drop and dwell expiry at the same boundary fold into one search.
        rearb = !(|(req & grant_q)) || ((dwell_q == DWELL_LAST) && !hold);
      end
      if (rearb) begin
        dwell_d = '0;
        if (pick[2]) begin
          state_d = SHOW;
          grant_d = 4'b0001 << pick[1:0];
          last_d  = pick[1:0];
        end else begin
          state_d = IDLE;
          grant_d = 4'b0000;
        end
      end else if (dwell_q != DWELL_LAST) begin
        // Saturates while hold pins an expired grantee, so rotation resumes
        // at the first boundary after hold is released.
        dwell_d = dwell_q + 1'b1;
      end
      if (state_d == SHOW) value_d = data[{last_d, 4'b0000} +: 16];
    end
  end

`ifdef SEG_LZ_BLANK_EN
  logic [1:0] msd;  // highest nonzero nibble of the latched value (0 if none)
  always_comb begin
    msd = 2'd0;
    for (int i = 1; i < NUM_DIGITS; i++) begin
      if (value_q[4*i +: 4] != 4'h0) msd = 2'(i);
    end
  end
`endif

  // Digit drive, computed from the current scan state and registered.
  always_comb begin
    sel_d  = SEL_OFF;
    seg_d  = SEG_BLANK;
    nibble = value_q[{digit, 2'b00} +: 4];
    if (!blank && (grant_q != 4'b0000)) begin
      sel_d = ~(4'b0001 << digit);
      seg_d = {1'b0, nibble};
`ifdef SEG_LZ_BLANK_EN
      if (digit > msd) seg_d = SEG_BLANK;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= 4'b0000;
      last_q  <= 2'd3;
      dwell_q <= '0;
      value_q <= 16'h0000;
      sel_q   <= SEL_OFF;
      seg_q   <= SEG_BLANK;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      dwell_q <= dwell_d;
      value_q <= value_d;
      sel_q   <= sel_d;
      seg_q   <= seg_d;
      tick_q  <= boundary;
    end
  end

  assign grant      = grant_q;
  assign sel        = sel_q;
  assign seg_code   = seg_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Bench for seg_display_arbiter with SCAN_DIV=8, BLANK_CYC=2, DWELL_FRAMES=2.
// A cycle-count based model predicts grant/sel/seg_code/frame_tick for every
// clock; directed scenarios add hand-computed literal checks, then a random
// phase exercises requests, hold and data changes.
module tb_seg_display_arbiter;

  localparam int SCAN_DIV     = 8;
  localparam int BLANK_CYC    = 2;
  localparam int DWELL_FRAMES = 2;
  localparam int FRAME        = SCAN_DIV * 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req = 4'b0000;
  logic [63:0] data = 64'h0;
  logic        hold = 1'b0;
  logic [3:0]  grant;
  logic [4:0]  seg_code;
  logic [3:0]  sel;
  logic        frame_tick;

  int n_tests = 0;
  int n_fail  = 0;

  seg_display_arbiter #(
    .SCAN_DIV    (SCAN_DIV),
    .BLANK_CYC   (BLANK_CYC),
    .DWELL_FRAMES(DWELL_FRAMES)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .data      (data),
    .hold      (hold),
    .grant     (grant),
    .seg_code  (seg_code),
    .sel       (sel),
    .frame_tick(frame_tick)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  // m_cnt = cycles since reset release = scan position.
  int          m_cnt   = 0;
  int          m_gidx  = -1;   // -1: nothing granted
  int          m_last  = 3;
  int          m_dwell = 0;
  logic [15:0] m_value = 16'h0;
  logic [13:0] exp_q[$];       // {grant, sel, seg_code, frame_tick}

  task automatic model_reset();
    m_cnt   = 0;
    m_gidx  = -1;
    m_last  = 3;
    m_dwell = 0;
    m_value = 16'h0;
    exp_q.delete();
  endtask

  task automatic model_step();
    int          slot, digit, nxt;
    bit          bnd, rearb;
    logic [3:0]  e_sel, e_grant;
    logic [4:0]  e_seg;
    logic [15:0] sh;
    slot  = m_cnt % SCAN_DIV;
    digit = (m_cnt / SCAN_DIV) % 4;
    bnd   = ((m_cnt % FRAME) == FRAME - 1);
    e_sel = 4'hF;
    e_seg = 5'h10;
    if (slot >= BLANK_CYC && m_gidx >= 0) begin
      e_sel = 4'hF ^ (4'b0001 << digit);
      sh    = m_value >> (4 * digit);
      e_seg = {1'b0, sh[3:0]};
`ifdef SEG_LZ_BLANK_EN
      begin : lz
        int hi;
        logic [15:0] t;
        hi = 0;
        for (int i = 0; i < 4; i++) begin
          t = m_value >> (4 * i);
          if (t[3:0] != 4'h0) hi = i;
        end
        if (digit > hi) e_seg = 5'h10;
      end
`endif
    end
    if (bnd) begin
      if (m_gidx < 0) rearb = 1'b1;
      else rearb = (req[m_gidx] == 1'b0) || ((m_dwell >= DWELL_FRAMES - 1) && !hold);
      if (rearb) begin
        m_dwell = 0;
        nxt = -1;
        for (int k = 1; k <= 4; k++) begin
          if (nxt < 0 && req[(m_last + k) % 4]) nxt = (m_last + k) % 4;
        end
        m_gidx = nxt;
        if (nxt >= 0) m_last = nxt;
      end else if (m_dwell < DWELL_FRAMES - 1) begin
        m_dwell++;
      end
      if (m_gidx >= 0) m_value = data[16*m_gidx +: 16];
    end
    e_grant = (m_gidx < 0) ? 4'b0000 : (4'b0001 << m_gidx);
    exp_q.push_back({e_grant, e_sel, e_seg, bnd});
    m_cnt++;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else model_step();
  end

  // ---------------- scoreboard ----------------
  function automatic void chk(input string name, input logic [31:0] act,
                              input logic [31:0] exp_v);
    n_tests++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp_v);
    end
  endfunction

  always @(negedge clk) begin
    logic [13:0] e;
    if (rst_n && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("cyc_grant", 32'(grant), 32'(e[13:10]));
      chk("cyc_sel", 32'(sel), 32'(e[9:6]));
      chk("cyc_seg", 32'(seg_code), 32'(e[5:1]));
      chk("cyc_tick", 32'(frame_tick), 32'(e[0]));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Return at the negedge where the outputs reflect scan state s.
  task automatic wait_state(input int s);
    int guard;
    guard = 0;
    while (m_cnt != s + 1 && guard < 4000) begin
      @(negedge clk);
      guard++;
    end
    if (m_cnt != s + 1) begin
      n_tests++;
      n_fail++;
      $display("FAIL wait_state: reached %0d, required %0d", m_cnt, s + 1);
    end
  endtask

  task automatic chk_disp(input string name, input int s, input logic [3:0] e_sel,
                          input logic [4:0] e_seg);
    wait_state(s);
    chk({name, "_sel"}, 32'(sel), 32'(e_sel));
    chk({name, "_seg"}, 32'(seg_code), 32'(e_seg));
  endtask

  task automatic chk_grant(input string name, input int s, input logic [3:0] e_g);
    wait_state(s);
    chk(name, 32'(grant), 32'(e_g));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [4:0] lz_code;
`ifdef SEG_LZ_BLANK_EN
    lz_code = 5'h10;
`else
    lz_code = 5'h00;
`endif

    // Single requester, hex digits 12AB.
    do_reset();
    req = 4'b0001;
    data = 64'h0;
    data[15:0] = 16'h12AB;
    wait_state(30);
    chk("b_tick_pre", 32'(frame_tick), 32'd0);
    chk("b_grant_pre", 32'(grant), 32'd0);
    wait_state(31);
    chk("b_tick", 32'(frame_tick), 32'd1);
    chk("b_grant", 32'(grant), 32'b0001);
    chk_disp("b_blank0", 32, 4'hF, 5'h10);
    chk_disp("b_blank1", 33, 4'hF, 5'h10);
    chk_disp("b_dig0", 34, 4'b1110, 5'h0B);
    chk_disp("b_dig1", 42, 4'b1101, 5'h0A);
    chk_disp("b_dig2", 50, 4'b1011, 5'h02);
    chk_disp("b_dig3", 58, 4'b0111, 5'h01);

    // Reset asserted mid-slot while displaying.
    wait_state(61);
    #3 rst_n = 1'b0;
    #1;
    chk("a_rst_sel", 32'(sel), 32'hF);
    chk("a_rst_seg", 32'(seg_code), 32'h10);
    chk("a_rst_grant", 32'(grant), 32'h0);
    chk("a_rst_tick", 32'(frame_tick), 32'h0);
    @(posedge clk);
    #1;
    chk("a_rst_sel2", 32'(sel), 32'hF);
    chk("a_rst_seg2", 32'(seg_code), 32'h10);
    @(negedge clk);
    rst_n = 1'b1;
    chk_grant("a_idle", 2, 4'b0000);
    wait_state(30);
    chk("a_tick_pre", 32'(frame_tick), 32'd0);
    chk_grant("a_grant", 31, 4'b0001);
    chk_disp("a_dig0", 34, 4'b1110, 5'h0B);

    // Round robin between requesters 0 and 2, then hold.
    do_reset();
    req = 4'b0101;
    data = {16'h0, 16'h3333, 16'h0, 16'h1111};
    chk_grant("c_f1", 42, 4'b0001);
    chk_grant("c_f2", 74, 4'b0001);
    chk_grant("c_f3", 106, 4'b0100);
    chk_grant("c_f4", 138, 4'b0100);
    chk_grant("c_f5", 170, 4'b0001);
    hold = 1'b1;
    chk_grant("c_hold1", 234, 4'b0001);
    chk_grant("c_hold2", 266, 4'b0001);
    hold = 1'b0;
    chk_grant("c_release", 298, 4'b0100);

    // Grantee drops mid-frame, requester 1 waiting; then everyone drops.
    do_reset();
    req = 4'b0001;
    data = {16'h0, 16'h0, 16'h00CD, 16'h0000};
    wait_state(40);
    req = 4'b0010;
    chk_grant("d_keep1", 50, 4'b0001);
    chk_grant("d_keep2", 62, 4'b0001);
    chk_grant("d_move", 66, 4'b0010);
    chk("d_move_sel", 32'(sel), 32'b1110);
    chk("d_move_seg", 32'(seg_code), 32'h0D);
    wait_state(70);
    req = 4'b0000;
    chk_grant("d_idle", 100, 4'b0000);
    chk("d_idle_sel", 32'(sel), 32'hF);
    chk("d_idle_seg", 32'(seg_code), 32'h10);

    // Data change mid-frame must wait for the next boundary.
    do_reset();
    req = 4'b0001;
    data = 64'h0;
    data[15:0] = 16'h1234;
    wait_state(44);
    data[15:0] = 16'hFFFF;
    chk_disp("e_old2", 50, 4'b1011, 5'h02);
    chk_disp("e_old3", 58, 4'b0111, 5'h01);
    chk_disp("e_new0", 66, 4'b1110, 5'h0F);
    chk_disp("e_new3", 90, 4'b0111, 5'h0F);

    // Leading zeros.
    do_reset();
    req = 4'b0001;
    data = 64'h0;
    data[15:0] = 16'h0005;
    chk_disp("f_dig0", 34, 4'b1110, 5'h05);
    chk_disp("f_dig1", 42, 4'b1101, lz_code);
    chk_disp("f_dig3", 58, 4'b0111, lz_code);

    // Random phase, checked cycle by cycle against the model.
    do_reset();
    for (int f = 0; f < 40; f++) begin
      for (int c = 0; c < FRAME; c++) begin
        @(negedge clk);
        if ($urandom_range(0, 7) == 0) req = 4'($urandom_range(0, 15));
        if (c == 5) hold = ($urandom_range(0, 3) == 0);
        if ($urandom_range(0, 3) == 0) data = {$urandom, $urandom};
      end
    end

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/seg_display_arbiter.md
SEG_DISPLAY_ARBITER -- requirements
Module: seg_display_arbiter

Interface
REQ-001 The block SHALL have parameter SCAN_DIV, default 166667, meaning clk cycles per digit slot (300 slots/s at 50 MHz).
REQ-002 The block SHALL have parameter BLANK_CYC, default 1000, meaning anti-ghost blank cycles at each slot start (0 = none).
REQ-003 The block SHALL have parameter DWELL_FRAMES, default 75, meaning frames a grantee holds the display before rotation.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock.
REQ-005 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 The block SHALL have port req, input, 4 bits: display request per requester.
REQ-007 The block SHALL have port data, input, 64 bits: requester i value in data[16i+15:16i].
REQ-008 The block SHALL have port hold, input, 1 bit: freeze rotation on the current grantee.
REQ-009 The block SHALL have port grant, output, 4 bits: one-hot current grantee (0 = none).
REQ-010 The block SHALL have port seg_code, output, 5 bits: digit code to segLED (0..15 = hex nibble, 5'h10 = blank).
REQ-011 The block SHALL have port sel, output, 4 bits: active-low digit select (4'b1110 = digit 0, 4'b1111 = all off).
REQ-012 The block SHALL have port frame_tick, output, 1 bit: one-cycle pulse on the first cycle of each frame.

Function
REQ-013 The slot counter SHALL count 0..SCAN_DIV-1 and wrap; each wrap SHALL advance the digit index 0,1,2,3,0.
REQ-014 A frame boundary SHALL be the cycle with slot counter = SCAN_DIV-1 and digit index = 3.
REQ-015 While slot counter < BLANK_CYC, or while grant = 0, sel SHALL be 4'b1111 and seg_code SHALL be 5'h10.
REQ-016 Otherwise, sel SHALL be the active-low one-hot of the digit index, and seg_code SHALL be {1'b0, nibble[index]} of the latched value.
REQ-017 sel and seg_code SHALL be registered, lagging the counter state by exactly one cycle.
REQ-018 The FSM SHALL have two states: IDLE (grant = 0) and SHOW (grant != 0); grant updates SHALL occur only at frame boundaries.
REQ-019 At a frame boundary, IDLE SHALL go to SHOW if any req is high, granting the lowest-index requester after the last grantee in round-robin order.
REQ-020 At a frame boundary in SHOW, the block SHALL re-arbitrate when the grantee's req = 0, or when the dwell count = DWELL_FRAMES-1 and hold = 0.
REQ-021 Re-arbitration SHALL search from grantee+1 with wrap-around, may re-select the same grantee, and SHALL go to IDLE if no req is high.
REQ-022 Otherwise the dwell count SHALL increment; it SHALL clear on every re-arbitration.
REQ-023 A grantee dropping req mid-frame SHALL keep grant until the next frame boundary.
REQ-024 When the grantee's req drops and dwell expiry occur at the same boundary, they SHALL count as a single re-arbitration.
REQ-025 At each frame boundary, the 16-bit value of the new grantee SHALL be latched; data changes mid-frame SHALL NOT affect the display.
REQ-026 frame_tick SHALL be high in the cycle after each frame boundary.
REQ-027 SCAN_DIV > BLANK_CYC and DWELL_FRAMES >= 1 SHALL be required.

Reset
REQ-028 On rst_n low, asynchronously: counters, digit index and dwell = 0; grant = 0; last grantee = 3; latched value = 0; sel = 4'b1111; seg_code = 5'h10; frame_tick = 0.
REQ-029 A reset mid-slot or mid-frame SHALL restart the scan at digit 0, slot 0, in IDLE.

Configuration
REQ-030 When SEG_LZ_BLANK_EN is defined, digits above the highest nonzero nibble of the latched value SHALL show 5'h10 (sel unchanged), and digit 0 SHALL always show.
REQ-031 When SEG_LZ_BLANK_EN is undefined, all four nibbles SHALL be shown, including leading zeros.

Structure
REQ-032 Shared package seg_pkg SHALL hold SEG_BLANK (5'h10), SEL_OFF (4'b1111), NUM_DIGITS (4) and the IDLE/SHOW state typedef.
REQ-033 Sub-module seg_scan_timer SHALL own the slot counter, digit index, blank window and frame-boundary strobe.

Verification (SCAN_DIV=8, BLANK_CYC=2, DWELL_FRAMES=2)
REQ-034 The bench SHALL cover: reset asserted mid-slot -> next cycle sel=1111, seg_code=10h, grant=0, and frame_tick=0 until the first boundary.
REQ-035 The bench SHALL cover: req=0001, data[15:0]=16'h12AB -> after boundary grant=0001; digit 0 shows 2 blank cycles then seg_code=0Bh with sel=1110; digit 3 shows 01h with sel=0111.
REQ-036 The bench SHALL cover: req=0101 -> grant 0001 for 2 frames, then 0100 for 2 frames, then 0001; with hold=1, grant stays 0001.
REQ-037 The bench SHALL cover: grantee req dropped mid-frame with req[1]=1 -> grant unchanged to boundary, then 0010; all req dropped -> IDLE, blank.
REQ-038 The bench SHALL cover: data[15:0] changed 16'h1234->16'hFFFF mid-frame -> remaining digits show 1234, and next frame shows FFFF.
REQ-039 The bench SHALL cover: data=16'h0005 -> with SEG_LZ_BLANK_EN digits 3..1 show 10h and digit 0 shows 05h; without it the digits show 00h,00h,00h,05h.
